rmii_rx_gearbox: RTL and testbench

RMII_RX_GEARBOX -- requirements
Module: rmii_rx_gearbox

---
 rtl/rmii_rx_gearbox.sv | 199 +++++++++++++++++++
 tb/tb_rmii_rx_gearbox.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_rx_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : rmii_rx_gearbox
// Description : RMII receive dibit-to-word gearbox with preamble/SFD hunt and
//               sof/eof/err framing. Define RMII_SPEED_10M_EN for 10 Mb/s.
// Revision    : 1.0 - initial release
// ============================================================================
module rmii_rx_gearbox #(
    parameter int OUT_W        = 4,
    parameter int PREAMBLE_MIN = 4
) (
    input  logic             eth_rmii_clk,
    input  logic             sys_rst,
    input  logic             speed_sel,
    input  logic             rx_dv,
    input  logic [1:0]       rx_data,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_err
);

    localparam logic [1:0] LAST_DIB = 2'(OUT_W / 2 - 1);
    localparam logic [3:0] PRE_MIN  = 4'(PREAMBLE_MIN);
    localparam logic [3:0] PRE_MAX  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_DATA     = 2'd2,
        S_ABORT    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             dv_q;
    logic [1:0]       rxd_q;
    logic [3:0]       pre_cnt_q, pre_cnt_d;
    logic [1:0]       dib_cnt_q, dib_cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             first_q, first_d;
    logic             out_valid_d, out_sof_d, out_eof_d, out_err_d;
    logic [OUT_W-1:0] out_data_d;
    logic [OUT_W-1:0] word;
    logic             sample_en;

`ifdef RMII_SPEED_10M_EN
    logic [3:0] div_q, div_d;
    logic       speed_q, speed_d;
    logic       slow;

    // Speed is followed live only while idle; a frame keeps the speed it started with.
    always_comb begin
        slow      = (state_q == S_IDLE) ? speed_sel : speed_q;
        sample_en = !slow || (div_q == 4'd0);
        div_d     = (!dv_q || div_q == 4'd9) ? 4'd0 : div_q + 4'd1;
        speed_d   = speed_q;
        if (state_q == S_IDLE && state_d == S_PREAMBLE) begin
            speed_d = speed_sel;
        end
    end

    always_ff @(posedge eth_rmii_clk) begin
        if (sys_rst) begin
            div_q   <= 4'd0;
            speed_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            speed_q <= speed_d;
        end
    end
`else
    logic unused_speed_sel;
    assign unused_speed_sel = speed_sel;
    assign sample_en        = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        dib_cnt_d   = dib_cnt_q;
        acc_d       = acc_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        first_d     = first_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        out_err_d   = 1'b0;
        word        = {rxd_q, acc_q[OUT_W-1:2]};

        case (state_q)
            S_IDLE: begin
                if (dv_q && sample_en && rxd_q == 2'b01) begin
                    state_d   = S_PREAMBLE;
                    pre_cnt_d = 4'd1;
                end
            end
            S_PREAMBLE: begin
                if (!dv_q) begin
                    state_d = S_IDLE;
                end else if (sample_en) begin
                    case (rxd_q)
                        2'b01: begin
                            if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 4'd1;
                        end
                        2'b11: begin
                            if (pre_cnt_q >= PRE_MIN) begin
                                state_d    = S_DATA;
                                dib_cnt_d  = 2'd0;
                                acc_d      = '0;
                                hold_vld_d = 1'b0;
                                first_d    = 1'b1;
                            end else begin
                                state_d = S_ABORT;
                            end
                        end
                        default: state_d = S_ABORT;
                    endcase
                end
            end
            S_DATA: begin
                if (!dv_q) begin
                    // Flush the held word as the last one; leftover dibits mark it errored.
                    if (hold_vld_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = hold_q;
                        out_sof_d   = first_q;
                        out_eof_d   = 1'b1;
                        out_err_d   = (dib_cnt_q != 2'd0);
                    end
                    state_d    = S_IDLE;
                    dib_cnt_d  = 2'd0;
                    acc_d      = '0;
                    hold_vld_d = 1'b0;
                    first_d    = 1'b0;
                end else if (sample_en) begin
                    acc_d = word;
                    if (dib_cnt_q == LAST_DIB) begin
                        dib_cnt_d = 2'd0;
                        if (hold_vld_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = hold_q;
                            out_sof_d   = first_q;
                            first_d     = 1'b0;
                        end
                        hold_d     = word;
                        hold_vld_d = 1'b1;
                    end else begin
                        dib_cnt_d = dib_cnt_q + 2'd1;
                    end
                end
            end
            S_ABORT: begin
                if (!dv_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge eth_rmii_clk) begin
        if (sys_rst) begin
            dv_q       <= 1'b0;
            rxd_q      <= 2'b00;
            state_q    <= S_IDLE;
            pre_cnt_q  <= 4'd0;
            dib_cnt_q  <= 2'd0;
            acc_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            first_q    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            dv_q       <= rx_dv;
            rxd_q      <= rx_data;
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            dib_cnt_q  <= dib_cnt_d;
            acc_q      <= acc_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            first_q    <= first_d;
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            out_sof    <= out_sof_d;
            out_eof    <= out_eof_d;
            out_err    <= out_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rmii_rx_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_rmii_rx_gearbox
// Description : Self-checking bench driving 4-bit and 8-bit gearboxes in
//               parallel against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rmii_rx_gearbox;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
    } word_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       speed_sel = 1'b0;
    logic       rx_dv = 1'b0;
    logic [1:0] rx_data = 2'b00;

    logic       v4, s4, e4, r4, v8, s8, e8, r8;
    logic [3:0] d4;
    logic [7:0] d8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stray = 0;
    int eof8_cyc = -1;
    int drop_cyc = 0;

    logic [1:0] pay[$];
    logic [1:0] fr[$];
    word_t      got4[$], got8[$], exp4[$], exp8[$];

    always #5 clk = ~clk;

    rmii_rx_gearbox #(.OUT_W(4), .PREAMBLE_MIN(4)) u_dut4 (
        .eth_rmii_clk(clk), .sys_rst(rst), .speed_sel(speed_sel),
        .rx_dv(rx_dv), .rx_data(rx_data), .out_valid(v4), .out_data(d4),
        .out_sof(s4), .out_eof(e4), .out_err(r4)
    );

    rmii_rx_gearbox #(.OUT_W(8), .PREAMBLE_MIN(4)) u_dut8 (
        .eth_rmii_clk(clk), .sys_rst(rst), .speed_sel(speed_sel),
        .rx_dv(rx_dv), .rx_data(rx_data), .out_valid(v8), .out_data(d8),
        .out_sof(s8), .out_eof(e8), .out_err(r8)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v4) got4.push_back({4'b0000, d4, s4, e4, r4});
        else if ({d4, s4, e4, r4} != 7'd0) stray++;
        if (v8) got8.push_back({d8, s8, e8, r8});
        else if ({d8, s8, e8, r8} != 11'd0) stray++;
        if (v8 && e8) eof8_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        pay.push_back(b[1:0]);
        pay.push_back(b[3:2]);
        pay.push_back(b[5:4]);
        pay.push_back(b[7:6]);
    endtask

    task automatic make_frame(input int junk, input int n01, input logic [1:0] term);
        fr.delete();
        repeat (junk) fr.push_back(2'b00);
        repeat (n01) fr.push_back(2'b01);
        fr.push_back(term);
        foreach (pay[i]) fr.push_back(pay[i]);
    endtask

    // Expected words: payload dibits grouped LSB-first, sof on the first word,
    // eof on the last, err when leftover dibits did not fill a word.
    task automatic compute_exp(input bit ok);
        int         h, n, rem;
        logic [7:0] val;
        word_t      w;
        exp4.delete();
        exp8.delete();
        if (ok) begin
            for (int ws = 0; ws < 2; ws++) begin
                h   = (ws == 1) ? 4 : 2;
                n   = pay.size() / h;
                rem = pay.size() % h;
                for (int k = 0; k < n; k++) begin
                    val = 8'd0;
                    for (int j = 0; j < h; j++) val = val | (8'(pay[k*h+j]) << (2*j));
                    w = {val, (k == 0), (k == n-1), (k == n-1) && (rem != 0)};
                    if (ws == 1) exp8.push_back(w);
                    else exp4.push_back(w);
                end
            end
        end
    endtask

    task automatic send(input int hold, input int rst_at);
        for (int i = 0; i < fr.size(); i++) begin
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                rst     = (i == rst_at) && (c == 0);
                rx_dv   = 1'b1;
                rx_data = fr[i];
            end
        end
        @(negedge clk);
        rst      = 1'b0;
        rx_dv    = 1'b0;
        rx_data  = 2'b00;
        drop_cyc = cyc;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_count4"}, got4.size(), exp4.size());
        for (int i = 0; i < got4.size() && i < exp4.size(); i++)
            chk({tag, "_word4"}, got4[i], exp4[i]);
        chk({tag, "_count8"}, got8.size(), exp8.size());
        for (int i = 0; i < got8.size() && i < exp8.size(); i++)
            chk({tag, "_word8"}, got8[i], exp8[i]);
        got4.delete();
        got8.delete();
    endtask

    task automatic good_frame(input string tag);
        pay.delete();
        push_byte(8'h3C);
        push_byte(8'hE7);
        make_frame(1, 31, 2'b11);
        compute_exp(1'b1);
        send(1, -1);
        check_frame(tag);
    endtask

    initial begin
        int         junk, n01, nb, r;
        logic [1:0] term;

        repeat (3) @(negedge clk);
        chk("reset_out4", {v4, d4, s4, e4, r4}, 0);
        chk("reset_out8", {v8, d8, s8, e8, r8}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 7x 0x55 + SFD 0xD5 is 31 dibits of 01 then 11; payload 0x12 0x34
        pay.delete();
        push_byte(8'h12);
        push_byte(8'h34);
        make_frame(0, 31, 2'b11);
        compute_exp(1'b1);
        eof8_cyc = -1;
        send(1, -1);
        chk("eof8_latency", eof8_cyc - drop_cyc, 2);
        check_frame("basic");

        pay.delete();
        push_byte(8'h12);
        pay.push_back(2'b10);
        make_frame(0, 31, 2'b11);
        compute_exp(1'b1);
        send(1, -1);
        check_frame("partial_err");

        pay.delete();
        push_byte(8'h77);
        make_frame(0, 2, 2'b11);
        compute_exp(1'b0);
        send(1, -1);
        check_frame("short_pre");

        make_frame(0, 20, 2'b10);
        compute_exp(1'b0);
        send(1, -1);
        check_frame("bad_pre");
        good_frame("after_bad");

        make_frame(0, 3, 2'b11);
        compute_exp(1'b0);
        send(1, -1);
        check_frame("pre_min_minus1");
        make_frame(0, 4, 2'b11);
        compute_exp(1'b1);
        send(1, -1);
        check_frame("pre_min_exact");

        pay.delete();
        pay.push_back(2'b11);
        make_frame(0, 8, 2'b11);
        compute_exp(1'b1);
        send(1, -1);
        check_frame("no_word");

        pay.delete();
        push_byte(8'h5A);
        make_frame(0, 8, 2'b11);
        compute_exp(1'b1);
        send(1, -1);
        check_frame("single_word");

        // Reset lands on the third payload dibit; the tail holds no 01 dibit.
        pay.delete();
        push_byte(8'hFA);
        push_byte(8'h0F);
        make_frame(0, 31, 2'b11);
        compute_exp(1'b0);
        send(1, 34);
        check_frame("mid_reset");
        good_frame("after_reset");

`ifdef RMII_SPEED_10M_EN
        speed_sel = 1'b1;
        pay.delete();
        push_byte(8'hA5);
        make_frame(0, 31, 2'b11);
        compute_exp(1'b1);
        send(10, -1);
        check_frame("slow_a5");
        speed_sel = 1'b0;
`else
        speed_sel = 1'b1;
        pay.delete();
        push_byte(8'hA5);
        make_frame(0, 31, 2'b11);
        compute_exp(1'b1);
        send(1, -1);
        check_frame("speed_ignored");
        speed_sel = 1'b0;
`endif

        for (int f = 0; f < 40; f++) begin
            junk = $urandom_range(0, 3);
            n01  = $urandom_range(1, 31);
            r    = $urandom_range(0, 9);
            term = (r < 7) ? 2'b11 : (r == 7) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
            nb   = $urandom_range(0, 6);
            pay.delete();
            repeat (nb) push_byte(8'($urandom));
            if ($urandom_range(0, 1) == 1) pay.push_back(2'($urandom));
            make_frame(junk, n01, term);
            compute_exp(term == 2'b11 && n01 >= 4);
            send(1, -1);
            check_frame("random");
        end

        chk("idle_outputs_zero", stray, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
